// File: rtl/draw_pixel_writer_if.sv
// VRAM write port between the pixel writer (master) and the VRAM arbiter (slave).
interface draw_pixel_writer_if #(
    parameter int ADDRW = 16
);
    logic             vram_wr_o;
    logic [ADDRW-1:0] vram_addr_o;
    logic [3:0]       vram_mask_o;
    logic [15:0]      vram_data_o;
    logic             vram_ack_i;

    modport master (
        output vram_wr_o,
        output vram_addr_o,
        output vram_mask_o,
        output vram_data_o,
        input  vram_ack_i
    );

    modport slave (
        input  vram_wr_o,
        input  vram_addr_o,
        input  vram_mask_o,
        input  vram_data_o,
        output vram_ack_i
    );
endinterface

// File: rtl/draw_pixel_writer.sv
// Clips drawer pixels, maps them to 4bpp VRAM words and coalesces same-word
// pixels into masked writes issued to the VRAM arbiter with a req/ack handshake.
module draw_pixel_writer #(
    parameter int CORDW = 16,
    parameter int ADDRW = 16
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [ADDRW-1:0]        base_i,
    input  logic [ADDRW-1:0]        line_len_i,
    input  logic signed [CORDW-1:0] clip_x0_i,
    input  logic signed [CORDW-1:0] clip_y0_i,
    input  logic signed [CORDW-1:0] clip_x1_i,
    input  logic signed [CORDW-1:0] clip_y1_i,
    input  logic [3:0]              color_i,
    input  logic signed [CORDW-1:0] x_i,
    input  logic signed [CORDW-1:0] y_i,
    input  logic                    drawing_i,
    input  logic                    draw_done_i,
    output logic                    oe_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    draw_pixel_writer_if.master     vram
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_n;

    // Latched primitive configuration
    logic [ADDRW-1:0]        r_base;
    logic [ADDRW-1:0]        r_line_len;
    logic signed [CORDW-1:0] r_clip_x0;
    logic signed [CORDW-1:0] r_clip_y0;
    logic signed [CORDW-1:0] r_clip_x1;
    logic signed [CORDW-1:0] r_clip_y1;
    logic [3:0]              r_color;

    // Two-entry input FIFO, entry 0 is the head; each entry is {x, y}
    logic [2*CORDW-1:0] r_fifo [2];
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_n;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    logic signed [CORDW-1:0] w_head_x;
    logic signed [CORDW-1:0] w_head_y;
    logic                    w_clip;
    logic [ADDRW-1:0]        w_row;
    logic [ADDRW-1:0]        w_word;

    // Stage A register
    logic             r_a_valid;
    logic [ADDRW-1:0] r_a_row;
    logic [ADDRW-1:0] r_a_word;
    logic [1:0]       r_a_nib;

    // Stage B (combinational into the pending word)
    logic [ADDRW-1:0] w_b_addr;
    logic [3:0]       w_b_mask;
    logic [3:0]       w_merged;

    // Pending word and write request
    logic             r_p_valid;
    logic [ADDRW-1:0] r_p_addr;
    logic [3:0]       r_p_mask;
    logic             r_wr;
    logic             r_oe;
    logic             r_overflow;

    logic             w_ack;
    logic             w_take;
    logic             w_issue;
    logic             w_p_valid_n;
    logic [ADDRW-1:0] w_p_addr_n;
    logic [3:0]       w_p_mask_n;
    logic             w_wr_n;
    logic             w_drain_ok;

    assign w_head_x = r_fifo[0][2*CORDW-1:CORDW];
    assign w_head_y = r_fifo[0][CORDW-1:0];

    assign w_clip = w_head_x[CORDW-1] | w_head_y[CORDW-1] |
                    (w_head_x < r_clip_x0) | (w_head_x > r_clip_x1) |
                    (w_head_y < r_clip_y0) | (w_head_y > r_clip_y1);

    assign w_row  = ADDRW'(w_head_y) * r_line_len;
    assign w_word = ADDRW'(w_head_x[CORDW-1:2]);

    assign w_b_addr = r_base + r_a_row + r_a_word;
    assign w_b_mask = 4'b1000 >> r_a_nib;
    assign w_merged = r_p_mask | w_b_mask;

    assign w_ack = r_wr & vram.vram_ack_i;

    assign w_push  = drawing_i && (r_state == S_RUN) && (r_cnt != 2'd2);
    assign w_drop  = drawing_i && (r_state == S_RUN) && (r_cnt == 2'd2);
    assign w_pop   = (r_cnt != 2'd0) && (!r_a_valid || w_take);
    assign w_cnt_n = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    // An acked write frees the pending slot in the same cycle, so a stalled
    // stage-A pixel can load straight into it at the ack edge.
    always_comb begin
        w_take      = 1'b0;
        w_issue     = 1'b0;
        w_p_valid_n = r_p_valid;
        w_p_addr_n  = r_p_addr;
        w_p_mask_n  = r_p_mask;
        w_wr_n      = r_wr;
        if (w_ack) begin
            w_p_valid_n = 1'b0;
            w_wr_n      = 1'b0;
        end
        if (r_a_valid) begin
            if (!r_p_valid || w_ack) begin
                w_take      = 1'b1;
                w_p_valid_n = 1'b1;
                w_p_addr_n  = w_b_addr;
                w_p_mask_n  = w_b_mask;
            end else if (!r_wr) begin
                if (r_p_addr == w_b_addr) begin
                    w_take     = 1'b1;
                    w_p_mask_n = w_merged;
                    w_issue    = (w_merged == 4'b1111);
                end else begin
                    w_issue = 1'b1;
                end
            end
        end else if (r_p_valid && !r_wr && (r_state == S_FLUSH) && (r_cnt == 2'd0)) begin
            w_issue = 1'b1;
        end
        if (w_issue) begin
            w_wr_n = 1'b1;
        end
    end

    assign w_drain_ok = (r_cnt == 2'd0) && !r_a_valid && (!r_p_valid || w_ack);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_n = S_RUN;
            S_RUN:   if (draw_done_i) w_state_n = S_FLUSH;
            S_FLUSH: if (w_drain_ok) w_state_n = S_DRAIN;
            S_DRAIN: w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_base     <= '0;
            r_line_len <= '0;
            r_clip_x0  <= '0;
            r_clip_y0  <= '0;
            r_clip_x1  <= '0;
            r_clip_y1  <= '0;
            r_color    <= '0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_cnt      <= '0;
            r_a_valid  <= 1'b0;
            r_a_row    <= '0;
            r_a_word   <= '0;
            r_a_nib    <= '0;
            r_p_valid  <= 1'b0;
            r_p_addr   <= '0;
            r_p_mask   <= '0;
            r_wr       <= 1'b0;
            r_oe       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_base     <= base_i;
                r_line_len <= line_len_i;
                r_clip_x0  <= clip_x0_i;
                r_clip_y0  <= clip_y0_i;
                r_clip_x1  <= clip_x1_i;
                r_clip_y1  <= clip_y1_i;
                r_color    <= color_i;
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // Push with pop only happens at count 1, so the new pixel becomes the head
            if (w_pop) begin
                r_fifo[0] <= w_push ? {x_i, y_i} : r_fifo[1];
            end else if (w_push) begin
                if (r_cnt == 2'd0) begin
                    r_fifo[0] <= {x_i, y_i};
                end else begin
                    r_fifo[1] <= {x_i, y_i};
                end
            end
            r_cnt <= w_cnt_n;

            if (w_pop) begin
                r_a_valid <= !w_clip;
                r_a_row   <= w_row;
                r_a_word  <= w_word;
                r_a_nib   <= w_head_x[1:0];
            end else if (w_take) begin
                r_a_valid <= 1'b0;
            end

            r_p_valid <= w_p_valid_n;
            r_p_addr  <= w_p_addr_n;
            r_p_mask  <= w_p_mask_n;
            r_wr      <= w_wr_n;
            r_oe      <= (w_state_n == S_RUN) && (w_cnt_n == 2'd0);
        end
    end

    assign oe_o       = r_oe;
    assign busy_o     = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done_o     = (r_state == S_DRAIN);
    assign overflow_o = r_overflow;

    assign vram.vram_wr_o   = r_wr;
    assign vram.vram_addr_o = r_p_addr;
    assign vram.vram_mask_o = r_p_mask;
    assign vram.vram_data_o = {4{r_color}};

endmodule

// File: tb/tb_draw_pixel_writer.sv
// Directed scenarios for draw_pixel_writer with hand-computed VRAM writes.
module tb_draw_pixel_writer;
    localparam int CORDW = 16;
    localparam int ADDRW = 16;

    logic                    clk = 1'b0;
    logic                    reset_i = 1'b1;
    logic                    start_i = 1'b0;
    logic [ADDRW-1:0]        base_i = '0;
    logic [ADDRW-1:0]        line_len_i = '0;
    logic signed [CORDW-1:0] clip_x0_i = '0;
    logic signed [CORDW-1:0] clip_y0_i = '0;
    logic signed [CORDW-1:0] clip_x1_i = '0;
    logic signed [CORDW-1:0] clip_y1_i = '0;
    logic [3:0]              color_i = '0;
    logic signed [CORDW-1:0] x_i = '0;
    logic signed [CORDW-1:0] y_i = '0;
    logic                    drawing_i = 1'b0;
    logic                    draw_done_i = 1'b0;
    logic                    oe_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    overflow_o;

    int total = 0;
    int bad = 0;
    int wr_rises = 0;
    logic wr_q = 1'b0;

    draw_pixel_writer_if #(.ADDRW(ADDRW)) vif ();

    draw_pixel_writer #(.CORDW(CORDW), .ADDRW(ADDRW)) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .base_i      (base_i),
        .line_len_i  (line_len_i),
        .clip_x0_i   (clip_x0_i),
        .clip_y0_i   (clip_y0_i),
        .clip_x1_i   (clip_x1_i),
        .clip_y1_i   (clip_y1_i),
        .color_i     (color_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .drawing_i   (drawing_i),
        .draw_done_i (draw_done_i),
        .oe_o        (oe_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .vram        (vif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vif.vram_wr_o && !wr_q) wr_rises++;
        wr_q <= vif.vram_wr_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prim(input logic [15:0] base, input logic [15:0] len, input logic [3:0] col);
        base_i = base;
        line_len_i = len;
        color_i = col;
        clip_x0_i = 16'sd0;
        clip_y0_i = 16'sd0;
        clip_x1_i = 16'sd319;
        clip_y1_i = 16'sd239;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_pixel(input int x, input int y);
        for (int i = 0; i < 20 && !oe_o; i++) tick();
        x_i = 16'(x);
        y_i = 16'(y);
        drawing_i = 1'b1;
        tick();
        drawing_i = 1'b0;
    endtask

    task automatic pulse_done();
        draw_done_i = 1'b1;
        tick();
        draw_done_i = 1'b0;
    endtask

    task automatic wait_wr(output bit ok);
        for (int i = 0; i < 30 && !vif.vram_wr_o; i++) tick();
        ok = vif.vram_wr_o;
    endtask

    task automatic ack_one();
        vif.vram_ack_i = 1'b1;
        tick();
        vif.vram_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        total++; if (vif.vram_wr_o !== 1'b0 || oe_o !== 1'b0) begin bad++; $display("FAIL reset_wr_oe: wr=%b oe=%b expected 0 0", vif.vram_wr_o, oe_o); end
        total++; if (vif.vram_addr_o !== 16'h0 || vif.vram_mask_o !== 4'h0 || vif.vram_data_o !== 16'h0) begin bad++; $display("FAIL reset_bus: addr=%h mask=%b data=%h expected 0", vif.vram_addr_o, vif.vram_mask_o, vif.vram_data_o); end
        total++; if (busy_o !== 1'b0 || done_o !== 1'b0 || overflow_o !== 1'b0) begin bad++; $display("FAIL reset_status: busy=%b done=%b ovf=%b expected 0 0 0", busy_o, done_o, overflow_o); end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_full_word();
        bit ok;
        int r0;
        r0 = wr_rises;
        start_prim(16'h1000, 16'd80, 4'd5);
        total++; if (busy_o !== 1'b1 || oe_o !== 1'b1) begin bad++; $display("FAIL start_busy_oe: busy=%b oe=%b expected 1 1", busy_o, oe_o); end
        send_pixel(4, 2);
        send_pixel(5, 2);
        send_pixel(6, 2);
        send_pixel(7, 2);
        pulse_done();
        wait_wr(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_wr_seen: wr=%b expected 1", vif.vram_wr_o); end
        total++; if (vif.vram_addr_o !== 16'h10A1 || vif.vram_mask_o !== 4'b1111 || vif.vram_data_o !== 16'h5555) begin bad++; $display("FAIL full_word: addr=%h mask=%b data=%h expected 10a1 1111 5555", vif.vram_addr_o, vif.vram_mask_o, vif.vram_data_o); end
        tick();
        total++; if (vif.vram_wr_o !== 1'b1 || vif.vram_addr_o !== 16'h10A1) begin bad++; $display("FAIL full_hold: wr=%b addr=%h expected 1 10a1", vif.vram_wr_o, vif.vram_addr_o); end
        ack_one();
        total++; if (done_o !== 1'b1 || vif.vram_wr_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL full_done: done=%b wr=%b busy=%b expected 1 0 0", done_o, vif.vram_wr_o, busy_o); end
        tick();
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL full_done_pulse: done=%b expected 0", done_o); end
        total++; if (wr_rises - r0 !== 1) begin bad++; $display("FAIL full_write_count: got %0d expected 1", wr_rises - r0); end
    endtask

    task automatic test_overflow();
        bit ok;
        start_prim(16'h1000, 16'd80, 4'd5);
        send_pixel(0, 0);
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            x_i = 16'(i);
            y_i = 16'sd1;
            drawing_i = 1'b1;
            tick();
        end
        drawing_i = 1'b0;
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set: ovf=%b expected 1", overflow_o); end
        total++; if (vif.vram_wr_o !== 1'b1 || vif.vram_addr_o !== 16'h1000 || vif.vram_mask_o !== 4'b1000) begin bad++; $display("FAIL ovf_first_wr: wr=%b addr=%h mask=%b expected 1 1000 1000", vif.vram_wr_o, vif.vram_addr_o, vif.vram_mask_o); end
        tick(); tick(); tick();
        ack_one();
        pulse_done();
        wait_wr(ok);
        total++; if (!ok || vif.vram_addr_o !== 16'h1050 || vif.vram_mask_o !== 4'b1110) begin bad++; $display("FAIL ovf_second_wr: wr=%b addr=%h mask=%b expected 1 1050 1110", vif.vram_wr_o, vif.vram_addr_o, vif.vram_mask_o); end
        ack_one();
        total++; if (done_o !== 1'b1 || overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_done_sticky: done=%b ovf=%b expected 1 1", done_o, overflow_o); end
        tick();
    endtask

    task automatic test_clipped();
        int r0;
        bit seen;
        r0 = wr_rises;
        seen = 1'b0;
        start_prim(16'h1000, 16'd80, 4'd5);
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL start_clears_ovf: ovf=%b expected 0", overflow_o); end
        send_pixel(-1, 0);
        send_pixel(320, 0);
        send_pixel(3, 240);
        pulse_done();
        for (int i = 0; i < 6 && !seen; i++) begin
            if (done_o) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL clip_done: done=%b expected 1 within 6 cycles", done_o); end
        total++; if (wr_rises - r0 !== 0 || vif.vram_wr_o !== 1'b0) begin bad++; $display("FAIL clip_no_write: writes=%0d wr=%b expected 0 0", wr_rises - r0, vif.vram_wr_o); end
        tick();
    endtask

    task automatic test_stall();
        bit ok;
        int stable;
        start_prim(16'h1000, 16'd80, 4'd5);
        send_pixel(1, 0);
        total++; if (oe_o !== 1'b0) begin bad++; $display("FAIL stall_oe_drop: oe=%b expected 0", oe_o); end
        send_pixel(8, 0);
        wait_wr(ok);
        total++; if (!ok || vif.vram_addr_o !== 16'h1000 || vif.vram_mask_o !== 4'b0100) begin bad++; $display("FAIL stall_first_wr: wr=%b addr=%h mask=%b expected 1 1000 0100", vif.vram_wr_o, vif.vram_addr_o, vif.vram_mask_o); end
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vif.vram_wr_o === 1'b1 && vif.vram_addr_o === 16'h1000 && vif.vram_mask_o === 4'b0100) stable++;
        end
        total++; if (stable !== 10) begin bad++; $display("FAIL stall_hold: stable=%0d expected 10", stable); end
        ack_one();
        total++; if (vif.vram_wr_o !== 1'b0) begin bad++; $display("FAIL stall_wr_fall: wr=%b expected 0", vif.vram_wr_o); end
        ack_one();
        ack_one();
        pulse_done();
        wait_wr(ok);
        total++; if (!ok || vif.vram_addr_o !== 16'h1002 || vif.vram_mask_o !== 4'b1000) begin bad++; $display("FAIL stall_second_wr: wr=%b addr=%h mask=%b expected 1 1002 1000", vif.vram_wr_o, vif.vram_addr_o, vif.vram_mask_o); end
        ack_one();
        total++; if (done_o !== 1'b1 || overflow_o !== 1'b0) begin bad++; $display("FAIL stall_done: done=%b ovf=%b expected 1 0", done_o, overflow_o); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        start_prim(16'h1000, 16'd80, 4'd5);
        send_pixel(0, 0);
        pulse_done();
        wait_wr(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_wr_seen: wr=%b expected 1", vif.vram_wr_o); end
        reset_i = 1'b1;
        tick();
        total++; if (vif.vram_wr_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_drop: wr=%b busy=%b expected 0 0", vif.vram_wr_o, busy_o); end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        bit ok;
        start_prim(16'hF000, 16'h4000, 4'hA);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wrap_start: busy=%b expected 1", busy_o); end
        send_pixel(0, 8);
        send_pixel(0, 8);
        send_pixel(4, 8);
        pulse_done();
        wait_wr(ok);
        total++; if (!ok || vif.vram_addr_o !== 16'hF000 || vif.vram_mask_o !== 4'b1000 || vif.vram_data_o !== 16'hAAAA) begin bad++; $display("FAIL wrap_first_wr: addr=%h mask=%b data=%h expected f000 1000 aaaa", vif.vram_addr_o, vif.vram_mask_o, vif.vram_data_o); end
        ack_one();
        wait_wr(ok);
        total++; if (!ok || vif.vram_addr_o !== 16'hF001 || vif.vram_mask_o !== 4'b1000) begin bad++; $display("FAIL wrap_second_wr: addr=%h mask=%b expected f001 1000", vif.vram_addr_o, vif.vram_mask_o); end
        ack_one();
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL wrap_done: done=%b expected 1", done_o); end
        tick();
    endtask

    initial begin
        vif.vram_ack_i = 1'b0;
        test_reset();
        test_full_word();
        test_overflow();
        test_clipped();
        test_stall();
        test_reset_mid_write();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_pixel_writer.md
Name: draw_pixel_writer

Overview:
- Downstream stage of the triangle-fill and line drawers. Consumes their (x_o, y_o, drawing_o, done_o) pixel stream and throttles it through the drawer's oe_i input.
- Clips each pixel, converts it to a 4bpp VRAM word address and nibble mask, and merges adjacent pixels of the same word into one masked write.
- Issues writes to the VRAM arbiter with a req/ack handshake, then signals completion once the last write is acknowledged.

Parameters:
- CORDW, 16, signed coordinate width (matches the drawers)
- ADDRW, 16, VRAM word address width

Ports:
- clk  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin new primitive; latches base_i, line_len_i, clip_*, color_i
- base_i  in  ADDRW  VRAM word address of pixel (0,0)
- line_len_i  in  ADDRW  words per line
- clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i  in  CORDW each  inclusive signed clip rectangle
- color_i  in  4  fill colour index
- x_i, y_i  in  CORDW each  signed pixel position from drawer
- drawing_i  in  1  pixel valid this cycle
- draw_done_i  in  1  drawer done pulse (end of stream)
- oe_o  out  1  output enable to drawer (ready)
- vram_wr_o  out  1  write request, held until ack
- vram_addr_o  out  ADDRW  word address
- vram_mask_o  out  4  nibble write mask; bit3 = x[1:0]==0 (leftmost pixel)
- vram_data_o  out  16  {color,color,color,color}
- vram_ack_i  in  1  arbiter accepted write this cycle
- busy_o  out  1  primitive in progress
- done_o  out  1  one-cycle pulse: all writes acked
- overflow_o  out  1  sticky: pixel presented while input FIFO full

Behaviour:
- Reset: oe_o=0, vram_wr_o=0, vram_addr_o=0, vram_mask_o=0, vram_data_o=0, busy_o=0, done_o=0, overflow_o=0, FIFO empty, pending empty, FSM IDLE. Reset mid-write drops the request; vram_wr_o is low in the cycle after reset_i.
- FSM: IDLE -> RUN on start_i (busy_o=1 next cycle; overflow_o cleared) -> FLUSH on draw_done_i -> DRAIN once FIFO, pipeline and pending are empty and no request is outstanding -> IDLE with done_o=1 for one cycle, busy_o=0. start_i outside IDLE is ignored.
- Input FIFO, depth 2:
  - Push when drawing_i=1 in RUN and count<2.
  - oe_o is registered, =1 iff in RUN and count==0 at the next edge, so the drawer may present one pixel in the cycle after oe_o falls.
  - drawing_i with count==2 drops the pixel and sets overflow_o.
  - drawing_i outside RUN is ignored.
- Stage A (pop when stage B free):
  - clip = x<0 | y<0 | x<clip_x0 | x>clip_x1 | y<clip_y0 | y>clip_y1, all signed.
  - Clipped pixels are discarded.
  - Otherwise register row = y*line_len truncated to ADDRW bits, plus word = x>>2 and nib = x[1:0].
- Stage B: addr = base + row + word, modulo 2^ADDRW; mask = 4'b1000 >> nib.
- Pending word (coalescing):
  - Empty: load addr/mask.
  - Same addr and not yet issued: OR in the mask.
  - Different addr: issue pending and stall stage B until ack, then load the new pixel.
  - Mask reaching 4'b1111: issue immediately.
  - FLUSH with pipeline empty: issue any pending word.
- Write handshake:
  - vram_wr_o rises the cycle after the issue decision.
  - addr/mask/data stay constant until the cycle vram_ack_i=1; vram_wr_o falls the next cycle.
  - ack while vram_wr_o=0 is ignored.
  - Back-to-back issue is allowed: the next request may assert the cycle after ack.
- Latency: an unclipped pixel pushed at cycle N with no stall reaches pending at N+3.
- Simultaneous events:
  - Push and pop in the same cycle keep count unchanged.
  - draw_done_i together with the final drawing_i still accepts that pixel.
- Duplicate pixels (same x,y) merge harmlessly.

Test Plan:
- base=0x1000, line_len=80, clip 0..319/0..239, color=5; pixels (4,2),(5,2),(6,2),(7,2), ack after 1 cycle -> one write addr=0x10A1, mask=1111, data=0x5555; done_o one cycle after ack.
- Pixels (-1,0),(320,0),(3,240) then done -> no vram_wr_o; done_o pulses within 6 cycles.
- Pixels (1,0),(8,0) with ack held low 10 cycles -> first write addr=base, mask=0100 holds stable 10 cycles; oe_o drops; no overflow; second write addr=base+2, mask=1000.
- drawing_i high 4 consecutive cycles, ignoring oe_o, ack stalled -> overflow_o=1, extra pixel dropped, remaining writes correct.
- reset_i asserted while vram_wr_o=1 -> vram_wr_o=0 and busy_o=0 next cycle; new start_i works normally.
- line_len=0x4000, y=8, base=0xF000 -> addr wraps to (0xF000+0x20000) mod 2^16 = 0xF000.
